fsk_frame_receiver: RTL
=======================

// Module: fsk_frame_receiver
// PURPOSE
//   Receive end of the FSK link: recovers asynchronous byte frames from a 1-bit FSK square wave (modulator output).
//   Per rising edge, edge-to-edge period gives the tone: long period = space (0), short = mark (1).
//   A UART-style framer (start, DATA_BITS LSB-first, stop) on the tone stream emits bytes with valid/error pulses.
//   Sits downstream of the FSK modulator / line, upstream of byte consumers; idle line is mark.
// PARAMETERS
//   DATA_BITS      8    data bits per frame
//   CLKS_PER_BIT   128  clk cycles per bit period (>= 4*MAX_PERIOD)
//   PERIOD_THRESH  10   edge-to-edge interval (clks) >= this => space(0), else mark(1)
//   MAX_PERIOD     32   no edge for this many clks => carrier lost
// PORTS
//   clk         in   1          system clock, all logic on rising edge
//   rst         in   1          asynchronous active-high reset
//   fsk_in      in   1          FSK square wave, asynchronous to clk
//   data_out    out  DATA_BITS  last received byte, held until next data_valid
//   data_valid  out  1          1-cycle pulse: data_out updated with good frame
//   frame_err   out  1          1-cycle pulse: bad stop bit or carrier lost mid-frame
//   carrier_ok  out  1          tone measurement valid
//   busy        out  1          framer not in IDLE
// BEHAVIOUR
//   Reset: data_out=0, data_valid=0, frame_err=0, carrier_ok=0, busy=0, tone=1, state=IDLE, counters=0.
//   Front end: 2-flop sync on fsk_in, edge = sync & ~sync_d; edge asserts 3 clks after fsk_in rises.
//   Period counter: cleared to 0 on edge cycle, else +1, saturating at MAX_PERIOD.
//     interval = period_cnt+1 at the edge (edge-to-edge distance in clks).
//   Carrier: period_cnt reaching MAX_PERIOD -> carrier_ok=0, tone forced 1.
//     First edge after loss only restarts counting (no classification); second edge classifies, sets carrier_ok=1.
//   Tone: on each classified edge, tone <= (interval >= PERIOD_THRESH) ? 0 : 1; held between edges.
//   Framer FSM (bit_cnt 0..CLKS_PER_BIT-1, idx 0..DATA_BITS-1):
//     IDLE : carrier_ok & tone==0 -> START, bit_cnt=0.
//     START: at bit_cnt==CLKS_PER_BIT/2-1: tone==0 -> DATA, bit_cnt=0, idx=0; tone==1 -> IDLE (glitch, no error).
//     DATA : at bit_cnt==CLKS_PER_BIT-1 sample tone into shift[idx] (LSB first);
//            idx==DATA_BITS-1 -> STOP, else idx+1.
//     STOP : at bit_cnt==CLKS_PER_BIT-1: tone==1 -> data_out<=shift, data_valid=1; tone==0 -> frame_err=1.
//            Pulses occur on the cycle after that sample; next cycle IDLE.
//     Loss of carrier in START/DATA/STOP -> IDLE next cycle, frame_err pulse, data_out unchanged.
//   busy=1 in START/DATA/STOP. data_valid and frame_err never both high.
//   Back-to-back frames: START may begin the cycle after STOP completes.
//   Start detection only from IDLE; tone changes mid-bit are ignored except at sample points.
//   rst mid-frame: immediate return to reset values, partial byte discarded.
// TESTING
//   1 Reset mid-frame (during DATA) -> all outputs 0 same cycle; no valid/err on release.
//   2 Mark tone (period 4) idle, then frame 0xA5 (space period 16, mark period 4, 128 clks/bit)
//     -> one data_valid, data_out=8'hA5, frame_err=0, busy low after stop.
//   3 Frame 0x3C with space tone in stop bit -> frame_err pulse once, data_out keeps previous 8'hA5.
//   4 Space burst of 40 clks then mark (start glitch) -> busy pulses, returns IDLE, no valid/err.
//   5 fsk_in held low 40 clks during bit 3 -> carrier_ok=0, frame_err pulse, IDLE;
//     carrier_ok=1 again on second edge of resumed tone.
//   6 Two back-to-back frames 0x00 and 0xFF -> two data_valid pulses, 10*128 clks apart, values in order.

Source files
------------

// File: rtl/fsk_frame_receiver.sv
// FSK frame receiver: measures edge-to-edge periods of a 1-bit FSK square
// wave to recover a mark/space tone stream, then frames UART-style bytes
// (start, DATA_BITS LSB-first, stop) out of that tone stream.
module fsk_frame_receiver #(
    parameter int DATA_BITS     = 8,
    parameter int CLKS_PER_BIT  = 128,
    parameter int PERIOD_THRESH = 10,
    parameter int MAX_PERIOD    = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 fsk_in,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    output logic                 frame_err,
    output logic                 carrier_ok,
    output logic                 busy
);

    localparam int PW = $clog2(MAX_PERIOD + 1);
    localparam int BW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [PW-1:0] CNT_MAX   = PW'(MAX_PERIOD);
    // interval = count + 1, so interval >= PERIOD_THRESH <=> count >= PERIOD_THRESH - 1
    localparam logic [PW-1:0] CNT_SPACE = PW'(PERIOD_THRESH - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] HALF_LAST = BW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(DATA_BITS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    logic                 r_sync1;
    logic                 r_sync2;
    logic                 r_sync_d;
    logic [PW-1:0]        r_period_cnt;
    logic                 r_armed;
    logic                 r_carrier_ok;
    logic                 r_tone;
    state_t               r_state;
    logic [BW-1:0]        r_bit_cnt;
    logic [IW-1:0]        r_idx;
    logic [DATA_BITS-1:0] r_shift;
    logic [DATA_BITS-1:0] r_data_out;
    logic                 r_data_valid;
    logic                 r_frame_err;
    logic                 r_busy;

    logic                 w_edge;
    logic                 w_lost;

    assign w_edge = r_sync2 & ~r_sync_d;
    // Counter sits at its ceiling only when no edge arrived for MAX_PERIOD clocks
    assign w_lost = (r_period_cnt == CNT_MAX);

    assign data_out   = r_data_out;
    assign data_valid = r_data_valid;
    assign frame_err  = r_frame_err;
    assign carrier_ok = r_carrier_ok;
    assign busy       = r_busy;

    // Two-flop synchroniser on the asynchronous line plus a delayed copy for rising-edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1  <= 1'b0;
            r_sync2  <= 1'b0;
            r_sync_d <= 1'b0;
        end else begin
            r_sync1  <= fsk_in;
            r_sync2  <= r_sync1;
            r_sync_d <= r_sync2;
        end
    end

    // Edge-to-edge period counter; saturates so a dead line stays flagged
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_period_cnt <= '0;
        end else if (w_edge) begin
            r_period_cnt <= '0;
        end else if (!w_lost) begin
            r_period_cnt <= r_period_cnt + 1'b1;
        end
    end

    // Carrier tracking and tone classification; after a loss the first edge only re-arms
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_armed      <= 1'b0;
            r_carrier_ok <= 1'b0;
            r_tone       <= 1'b1;
        end else if (w_edge) begin
            if (r_armed && !w_lost) begin
                r_carrier_ok <= 1'b1;
                r_tone       <= (r_period_cnt >= CNT_SPACE) ? 1'b0 : 1'b1;
            end else begin
                r_armed      <= 1'b1;
                r_carrier_ok <= 1'b0;
                r_tone       <= 1'b1;
            end
        end else if (w_lost) begin
            r_armed      <= 1'b0;
            r_carrier_ok <= 1'b0;
            r_tone       <= 1'b1;
        end
    end

    // Byte framer: start qualified at half-bit, data and stop sampled one bit period apart
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_bit_cnt    <= '0;
            r_idx        <= '0;
            r_shift      <= '0;
            r_data_out   <= '0;
            r_data_valid <= 1'b0;
            r_frame_err  <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_data_valid <= 1'b0;
            r_frame_err  <= 1'b0;
            if (r_state != S_IDLE && w_lost) begin
                // Carrier dropped mid-frame: abandon the partial byte
                r_state     <= S_IDLE;
                r_busy      <= 1'b0;
                r_bit_cnt   <= '0;
                r_frame_err <= 1'b1;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (r_carrier_ok && !w_lost && !r_tone) begin
                            r_state   <= S_START;
                            r_bit_cnt <= '0;
                            r_busy    <= 1'b1;
                        end
                    end
                    S_START: begin
                        if (r_bit_cnt == HALF_LAST) begin
                            r_bit_cnt <= '0;
                            if (!r_tone) begin
                                r_state <= S_DATA;
                                r_idx   <= '0;
                            end else begin
                                // Space did not last half a bit: treat as a glitch
                                r_state <= S_IDLE;
                                r_busy  <= 1'b0;
                            end
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                        end
                    end
                    S_DATA: begin
                        if (r_bit_cnt == BIT_LAST) begin
                            r_bit_cnt      <= '0;
                            r_shift[r_idx] <= r_tone;
                            if (r_idx == IDX_LAST) begin
                                r_state <= S_STOP;
                            end else begin
                                r_idx <= r_idx + 1'b1;
                            end
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                        end
                    end
                    S_STOP: begin
                        if (r_bit_cnt == BIT_LAST) begin
                            r_bit_cnt <= '0;
                            r_state   <= S_IDLE;
                            r_busy    <= 1'b0;
                            if (r_tone) begin
                                r_data_out   <= r_shift;
                                r_data_valid <= 1'b1;
                            end else begin
                                r_frame_err <= 1'b1;
                            end
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
